evm_ballot_unit: RTL and testbench
==================================

# evm_ballot_unit

Upstream front end of the voting machine: conditions the three raw candidate push-buttons and turns them into clean, one-cycle `candidate_1..3` vote pulses for the `evm` tally counter. It enforces one vote per ballot. The presiding-officer control issues `ballot_en`, the unit arms, accepts exactly one valid press, then locks until the next `ballot_en`. Multi-button presses are rejected, and `i_voting_over` closes the unit permanently until reset.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required before a button level change is accepted (≥1).
- `TIMEOUT_CYCLES`, default 1000: armed-ballot timeout; used only with `EVM_BALLOT_TIMEOUT_EN` (≥2).

Ports:
- `clk`, in, 1: single system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_1`, `btn_2`, `btn_3`, in, 1 each: raw asynchronous buttons, active-high.
- `ballot_en`, in, 1: synchronous pulse that arms one ballot.
- `i_voting_over`, in, 1: synchronous level; when high, no new ballot arms.
- `candidate_1`, `candidate_2`, `candidate_3`, out, 1 each: one-cycle vote pulses to `evm`.
- `ready`, out, 1: high while armed (voter LED).
- `reject`, out, 1: one-cycle pulse on a multi-press or timeout.
- `vote_done`, out, 1: one-cycle pulse, coincident with the candidate pulse.

## Operation
- Per button: 2-flop synchronizer, then debouncer.
- Debounced level changes only after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- A press event is a debounced rising edge.

FSM states: IDLE, ARMED, CAST, WAIT_REL, CLOSED.
- IDLE, `ballot_en` & !`i_voting_over` → ARMED.
- IDLE, `i_voting_over` → CLOSED.
- ARMED, any press event:
  - exactly one debounced button high → CAST;
  - two or more high → pulse `reject` and go to WAIT_REL; the ballot is spent and no vote is counted.
- CAST: assert that candidate's output plus `vote_done` for exactly one cycle → WAIT_REL.
- WAIT_REL, all debounced buttons low → IDLE, or → CLOSED if `i_voting_over`.
- CLOSED: absorbing until `rst_n` low; all outputs low.

Boundary rules:
- `ballot_en` in any state other than IDLE is ignored; no queuing.
- `i_voting_over` rising while ARMED: the ballot is cancelled → CLOSED, with no vote and no reject.
- Button held when a ballot arms: no press event is generated until it is released and pressed again.
- Reset mid-operation: state → IDLE, synchronizers and debounced levels → 0, counters cleared. No pulse is emitted on reset deassertion.

## Timing
- Reset values: `candidate_1..3` = 0, `ready` = 0, `reject` = 0, `vote_done` = 0.
- Raw edge sampled at edge k:
  - synchronized at k+2;
  - debounced high at k+2+`DEBOUNCE_CYCLES`;
  - candidate pulse high for the cycle following edge k+3+`DEBOUNCE_CYCLES`.
  - Default latency is 7 cycles.
- `ready` is high from the edge after `ballot_en` is sampled until the cycle CAST, WAIT_REL or CLOSED is entered.
- At most one candidate output is high in any cycle. No candidate output is ever high for two consecutive cycles.
- Release debounce uses the same count, so WAIT_REL exits no sooner than 2+`DEBOUNCE_CYCLES` cycles after the raw release.

## Configuration
- `EVM_BALLOT_TIMEOUT_EN` defined:
  - a counter runs in ARMED;
  - after `TIMEOUT_CYCLES` cycles with no press event → pulse `reject` → IDLE;
  - the counter clears on entry to ARMED.
- Not defined: no timeout counter is built, and ARMED waits indefinitely.

## Structure
- Shared package `evm_pkg`:
  - state enum (IDLE, ARMED, CAST, WAIT_REL, CLOSED);
  - candidate count localparam (3);
  - default `DEBOUNCE_CYCLES` / `TIMEOUT_CYCLES` constants.
- Sub-module `evm_debounce`: synchronizer plus debounce counter. Outputs the debounced level and a rise pulse. Instantiated three times.
- Top: FSM, one-hot vote decode, timeout counter.

## Test plan
- Reset, `ballot_en`, press `btn_2` for 10 cycles → `candidate_2` high for exactly 1 cycle, 7 cycles after sampling; `vote_done` coincident; `ready` falls.
- Press `btn_1` again without a new `ballot_en` → no pulse. Then `ballot_en` plus `btn_1` → `candidate_1` pulse. Through `evm`, `total1`=1 and `total2`=1.
- Armed, `btn_1` and `btn_3` pressed together → `reject` one pulse, no candidate pulse, then IDLE after release.
- Bounce `btn_3` (1-cycle glitches, gaps < `DEBOUNCE_CYCLES`), then hold → exactly one `candidate_3` pulse.
- `i_voting_over` high while armed → `ready` low, CLOSED. Later `ballot_en` and presses → no outputs. `rst_n` low → all outputs 0.
- With `EVM_BALLOT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20: arm and wait 20 cycles → `reject` pulse, `ready` low. A press afterwards → no vote.

Source files
------------

// File: rtl/evm_ballot_unit_pkg.sv
// Shared types and constants for the ballot front end: FSM state encoding,
// candidate count, default timing parameters and a button-count helper.
package evm_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      CAST     = 3'd2,
      WAIT_REL = 3'd3,
      CLOSED   = 3'd4
   } evm_state_e;

   localparam int unsigned NUM_CAND            = 3;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES  = 1000;

   // Number of debounced buttons currently held; distinguishes a clean press from a multi-press.
   function automatic logic [1:0] count_high(input logic [NUM_CAND-1:0] v);
      logic [1:0] n;
      n = 2'd0;
      for (int i = 0; i < NUM_CAND; i++) begin
         n = n + {1'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/evm_ballot_unit_debounce.sv
// One raw push-button: two-flop synchronizer followed by a debounce counter.
// Produces the debounced level and a one-cycle pulse on its rising edge.
module evm_debounce
   import evm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);

   localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic [1:0]    sync_q;
   logic          level_q;
   logic          level_d;
   logic          rise_q;
   logic          rise_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Debounce next-state: the level flips only after the synchronized value has
   // disagreed for DEBOUNCE_CYCLES counted cycles; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      if (sync_q[1] == level_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q == CNT_MAX) begin
         level_d = sync_q[1];
         cnt_d   = {CW{1'b0}};
         rise_d  = sync_q[1];
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Synchronizer and debounce state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= {CW{1'b0}};
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/evm_ballot_unit.sv
// Ballot front end: conditions three buttons and issues one vote pulse per armed ballot.
// Optional armed-ballot timeout is built when EVM_BALLOT_TIMEOUT_EN is defined.
module evm_ballot_unit
   import evm_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_1,
   input  logic btn_2,
   input  logic btn_3,
   input  logic ballot_en,
   input  logic i_voting_over,
   output logic candidate_1,
   output logic candidate_2,
   output logic candidate_3,
   output logic ready,
   output logic reject,
   output logic vote_done
);

   logic [NUM_CAND-1:0] btn_s;
   logic [NUM_CAND-1:0] level_s;
   logic [NUM_CAND-1:0] rise_s;
   logic                press_s;
   logic [1:0]          n_high_s;

   evm_state_e          state_q;
   logic [NUM_CAND-1:0] cand_q;
   logic                ready_q;
   logic                reject_q;
   logic                vote_done_q;

`ifdef EVM_BALLOT_TIMEOUT_EN
   localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]            tmo_cnt_q;
`endif

   assign btn_s = {btn_3, btn_2, btn_1};

   for (genvar g = 0; g < NUM_CAND; g++) begin : g_btn
      evm_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_i   (btn_s[g]),
         .level_o (level_s[g]),
         .rise_o  (rise_s[g])
      );
   end

   assign press_s  = |rise_s;
   assign n_high_s = count_high(level_s);

   // Ballot FSM with registered vote, ready, reject and done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cand_q      <= {NUM_CAND{1'b0}};
         ready_q     <= 1'b0;
         reject_q    <= 1'b0;
         vote_done_q <= 1'b0;
`ifdef EVM_BALLOT_TIMEOUT_EN
         tmo_cnt_q   <= {TW{1'b0}};
`else
`endif
      end else begin
         cand_q      <= {NUM_CAND{1'b0}};
         reject_q    <= 1'b0;
         vote_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_voting_over) begin
                  state_q <= CLOSED;
                  ready_q <= 1'b0;
               end else if (ballot_en) begin
                  state_q <= ARMED;
                  ready_q <= 1'b1;
`ifdef EVM_BALLOT_TIMEOUT_EN
                  tmo_cnt_q <= {TW{1'b0}};
`else
`endif
               end else begin
                  ready_q <= 1'b0;
               end
            end
            ARMED: begin
               // A press already held at arming has no rise, so it never votes here.
               if (i_voting_over) begin
                  state_q <= CLOSED;
                  ready_q <= 1'b0;
               end else if (press_s) begin
                  ready_q <= 1'b0;
                  if (n_high_s == 2'd1) begin
                     state_q     <= CAST;
                     cand_q      <= level_s;
                     vote_done_q <= 1'b1;
                  end else begin
                     state_q  <= WAIT_REL;
                     reject_q <= 1'b1;
                  end
               end
`ifdef EVM_BALLOT_TIMEOUT_EN
               else if (tmo_cnt_q == TMO_MAX) begin
                  state_q  <= IDLE;
                  ready_q  <= 1'b0;
                  reject_q <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TW'(1);
                  ready_q   <= 1'b1;
               end
`else
               else begin
                  ready_q <= 1'b1;
               end
`endif
            end
            CAST: begin
               state_q <= WAIT_REL;
               ready_q <= 1'b0;
            end
            WAIT_REL: begin
               ready_q <= 1'b0;
               if (level_s == {NUM_CAND{1'b0}}) begin
                  if (i_voting_over) begin
                     state_q <= CLOSED;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  state_q <= WAIT_REL;
               end
            end
            CLOSED: begin
               state_q <= CLOSED;
               ready_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign candidate_1 = cand_q[0];
   assign candidate_2 = cand_q[1];
   assign candidate_3 = cand_q[2];
   assign ready       = ready_q;
   assign reject      = reject_q;
   assign vote_done   = vote_done_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed bench for evm_ballot_unit with hand-computed cycle expectations.
// Covers the timeout path when EVM_BALLOT_TIMEOUT_EN is defined.
module tb_evm_ballot_unit;

`ifdef EVM_BALLOT_TIMEOUT_EN
   localparam int TMO = 20;
`else
   localparam int TMO = 1000;
`endif

   logic clk;
   logic rst_n;
   logic btn_1, btn_2, btn_3;
   logic ballot_en;
   logic i_voting_over;
   logic candidate_1, candidate_2, candidate_3;
   logic ready, reject, vote_done;

   int n_tests;
   int n_fail;
   int tally1, tally2, tally3;
   int n_multi, n_double;
   logic p1, p2, p3;

   evm_ballot_unit #(
      .DEBOUNCE_CYCLES (4),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .btn_1         (btn_1),
      .btn_2         (btn_2),
      .btn_3         (btn_3),
      .ballot_en     (ballot_en),
      .i_voting_over (i_voting_over),
      .candidate_1   (candidate_1),
      .candidate_2   (candidate_2),
      .candidate_3   (candidate_3),
      .ready         (ready),
      .reject        (reject),
      .vote_done     (vote_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tally of vote pulses as the evm counter would see them, plus pulse-shape invariants.
   always @(negedge clk) begin
      if (candidate_1) tally1 <= tally1 + 1;
      if (candidate_2) tally2 <= tally2 + 1;
      if (candidate_3) tally3 <= tally3 + 1;
      if ((int'(candidate_1) + int'(candidate_2) + int'(candidate_3)) > 1) n_multi <= n_multi + 1;
      if ((candidate_1 && p1) || (candidate_2 && p2) || (candidate_3 && p3)) n_double <= n_double + 1;
      p1 <= candidate_1;
      p2 <= candidate_2;
      p3 <= candidate_3;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic arm();
      ballot_en = 1'b1;
      tick(1);
      ballot_en = 1'b0;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      tally1 = 0; tally2 = 0; tally3 = 0;
      n_multi = 0; n_double = 0;
      p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
      rst_n = 1'b0;
      btn_1 = 1'b0; btn_2 = 1'b0; btn_3 = 1'b0;
      ballot_en = 1'b0; i_voting_over = 1'b0;

      tick(2);
      check_eq("rst_outputs", {26'd0, candidate_1, candidate_2, candidate_3, ready, reject, vote_done}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // Vote for candidate 2: pulse after 7 sampling edges, single cycle.
      arm();
      check_eq("ready_armed", ready, 1);
      btn_2 = 1'b1;
      tick(7);
      check_eq("c2_not_early", candidate_2, 0);
      check_eq("ready_before_cast", ready, 1);
      tick(1);
      check_eq("c2_pulse", candidate_2, 1);
      check_eq("vote_done_c2", vote_done, 1);
      check_eq("ready_fell", ready, 0);
      check_eq("c1_quiet", candidate_1, 0);
      tick(1);
      check_eq("c2_one_cycle", candidate_2, 0);
      check_eq("vote_done_one_cycle", vote_done, 0);
      tick(1);
      btn_2 = 1'b0;
      tick(10);

      // Press without a new ballot: no vote.
      btn_1 = 1'b1;
      tick(10);
      check_eq("no_vote_unarmed", tally1, 0);
      btn_1 = 1'b0;
      tick(10);
      arm();
      btn_1 = 1'b1;
      tick(8);
      check_eq("c1_pulse", candidate_1, 1);
      tick(2);
      btn_1 = 1'b0;
      tick(10);
      check_eq("total1", tally1, 1);
      check_eq("total2", tally2, 1);

      // Multi-press rejects and spends the ballot.
      arm();
      btn_1 = 1'b1; btn_3 = 1'b1;
      tick(8);
      check_eq("multi_reject", reject, 1);
      check_eq("multi_no_cand", {29'd0, candidate_1, candidate_2, candidate_3}, 0);
      check_eq("multi_ready_low", ready, 0);
      tick(1);
      check_eq("reject_one_cycle", reject, 0);
      btn_1 = 1'b0; btn_3 = 1'b0;
      tick(10);
      check_eq("multi_no_tally", tally1 + tally3, 1);

      // Back in IDLE: re-arm, bounce btn_3, then hold.
      arm();
      check_eq("rearm_after_release", ready, 1);
      for (int i = 0; i < 4; i++) begin
         btn_3 = 1'b1; tick(1);
         btn_3 = 1'b0; tick(2);
      end
      check_eq("bounce_no_vote", tally3, 0);
      check_eq("bounce_still_armed", ready, 1);
      btn_3 = 1'b1;
      tick(12);
      check_eq("bounce_single_c3", tally3, 1);
      btn_3 = 1'b0;
      tick(10);

      // Voting over while armed cancels the ballot and closes the unit.
      arm();
      check_eq("armed_before_close", ready, 1);
      i_voting_over = 1'b1;
      tick(1);
      check_eq("closed_ready_low", ready, 0);
      check_eq("closed_no_reject", reject, 0);
      i_voting_over = 1'b0;
      arm();
      btn_1 = 1'b1;
      tick(10);
      check_eq("closed_ignore_ballot", ready, 0);
      btn_1 = 1'b0;
      tick(10);
      check_eq("closed_no_votes", tally1 + tally2 + tally3, 3);
      rst_n = 1'b0;
      #1;
      check_eq("rst_all_low", {26'd0, candidate_1, candidate_2, candidate_3, ready, reject, vote_done}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

`ifdef EVM_BALLOT_TIMEOUT_EN
      arm();
      tick(19);
      check_eq("tmo_not_early", reject, 0);
      check_eq("tmo_ready_before", ready, 1);
      tick(1);
      check_eq("tmo_reject", reject, 1);
      check_eq("tmo_ready_low", ready, 0);
      tick(1);
      check_eq("tmo_reject_one_cycle", reject, 0);
      btn_2 = 1'b1;
      tick(10);
      btn_2 = 1'b0;
      tick(10);
      check_eq("tmo_no_vote", tally2, 1);
`else
      arm();
      tick(40);
      check_eq("no_tmo_ready", ready, 1);
      check_eq("no_tmo_reject", reject, 0);
`endif

      check_eq("one_hot_candidates", n_multi, 0);
      check_eq("no_double_pulse", n_double, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
